dmem_responder: RTL and testbench

Responder end of the single-cycle core's data-memory port. It accepts load/store requests from an initiator over a valid/ready handshake and holds them in a word-addressed RAM with byte-enable writes. It returns each result over a second valid/ready handshake after a programmable number of wait states. It sits between the core's load/store path and the data memory, and serves as both a multicycle memory model and the production memory front end.

---
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's data-memory port.
//
// Accepts one load/store at a time over req_valid/req_ready, waits WAIT
// cycles, performs the access against a word-addressed RAM built from four
// byte lanes, then holds the result on rsp_valid/rsp_rdata/rsp_err until the
// initiator takes it with rsp_ready.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_addr              byte address (must be word aligned and in range)
//   req_wdata, req_be     store data and byte enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data, 0 for stores and errors
//   rsp_err               misaligned or out-of-range request

// One byte lane of the RAM. No reset: contents survive reset.
module dmem_lane #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);
    logic [7:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module dmem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int NUM_LANES = 4;
    localparam int CW        = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t    cap_q, acc;
    logic    acc_en, acc_fire, acc_err, accept;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [NUM_LANES-1:0][7:0] rd_word;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign accept    = (state_q == ST_IDLE) && req_valid;

    // With WAIT = 0 the access happens on the accept edge, so it must use
    // the live request; otherwise it uses the copy captured at accept.
    always_comb begin
        acc = cap_q;
        if (state_q == ST_IDLE) acc = {req_we, req_addr, req_wdata, req_be};
    end

    assign acc_idx  = acc.addr[DEPTH_LOG2+1:2];
    assign acc_err  = (acc.addr[1:0] != 2'b00) || (acc.addr[31:DEPTH_LOG2+2] != '0);
    // Reset on the access edge discards the transaction, including its write.
    assign acc_fire = acc_en && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT == 0) begin
                        acc_en  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CW'(WAIT > 0 ? WAIT - 1 : 0);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    acc_en  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            dmem_lane #(.DEPTH_LOG2(DEPTH_LOG2)) u_lane (
                .clk  (clk),
                .we   (acc_fire && acc.we && !acc_err && acc.be[i]),
                .idx  (acc_idx),
                .wdata(acc.wdata[8*i +: 8]),
                .rdata(rd_word[i])
            );
        end
    endgenerate

    // Response is registered at the access edge and held through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) cap_q <= acc;
            if (acc_en) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc.we) ? 32'h0 : rd_word;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int WAIT  = 2;
    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(6), .WAIT(WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_LOG2(6), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem [WORDS];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0;
    int          hold = 0;
    bit          seen = 0, hs_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: memory as an array of words, rules applied arithmetically.
    function automatic exp_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        int   w;
        e.acc   = 0;
        e.err   = (addr % 4 != 0) || (addr >= 4 * WORDS);
        e.rdata = 32'h0;
        if (!e.err) begin
            w = int'(addr / 4);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[w][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e.rdata = mem[w];
            end
        end
        return e;
    endfunction

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input bit track);
        int   t = 0;
        exp_t e;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        if (track) begin
            e = model(we, addr, wd, be);
            e.acc = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        // Changing the inputs after accept must not affect the transaction.
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || rsp_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(sbq.size()), 32'h0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int r = int'($urandom_range(0, 9));
        if (r < 6)  return 32'($urandom_range(0, WORDS - 1) * 4);
        if (r == 6) return 32'($urandom_range(0, 255));
        if (r == 7) return 32'h100 + 32'($urandom_range(0, 63) * 4);
        if (r == 8) return 32'hFC;
        return $urandom;
    endfunction

    // Monitor: compares whenever a response is presented, owns rsp_ready.
    always @(negedge clk) begin
        if (reset) begin
            seen = 0; hs_prev = 0; rsp_ready = 1'b0;
        end else begin
            if (hs_prev) begin
                check("post_hs_rsp_valid", 32'(rsp_valid), 32'h0);
                check("post_hs_req_ready", 32'(req_ready), 32'h1);
                hs_prev = 0;
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'h0);
                    rsp_ready = 1'b1;
                end else begin
                    if (!seen) begin
                        check("latency", 32'(cyc - sbq[0].acc), 32'(WAIT));
                        seen = 1;
                    end
                    check("rsp_rdata", rsp_rdata, sbq[0].rdata);
                    check("rsp_err", 32'(rsp_err), 32'(sbq[0].err));
                    check("req_ready_busy", 32'(req_ready), 32'h0);
                    if (hold > 0) begin
                        rsp_ready = 1'b0;
                        hold--;
                    end else begin
                        rsp_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (rsp_ready) begin
                        void'(sbq.pop_front());
                        seen = 0;
                        hs_prev = 1;
                    end
                end
            end else begin
                rsp_ready = 1'($urandom);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
        z_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        reset = 1'b0;

        // Give every word a known value.
        for (int i = 0; i < WORDS; i++) send(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1);

        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        send(1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b1);
        send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        send(1'b1, 32'h10, 32'h12345678, 4'h0, 1'b1);
        send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        send(1'b0, 32'h12, 32'h0, 4'h0, 1'b1);
        send(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 1'b1);
        send(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

        // Backpressure: response held for 5 cycles.
        drain();
        hold = 5;
        send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        drain();

        // Reset in the second wait cycle of a store: it must never write.
        send(1'b1, 32'h20, 32'h11111111, 4'hF, 1'b1);
        drain();
        send(1'b1, 32'h20, 32'h22222222, 4'hF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_req_ready", 32'(req_ready), 32'h1);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_mid_rsp_err", 32'(rsp_err), 32'h0);
        reset = 1'b0;
        send(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);

        for (int n = 0; n < 300; n++)
            send(1'($urandom), rand_addr(), $urandom, 4'($urandom), 1'b1);
        drain();

        // Zero-wait-state instance: response the cycle after accept,
        // back-to-back requests accepted every other cycle.
        @(negedge clk);
        check("w0_req_ready", 32'(z_req_ready), 32'h1);
        z_req_we = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'hCAFEF00D; z_req_be = 4'hF;
        z_req_valid = 1'b1;
        @(negedge clk);
        check("w0_store_valid", 32'(z_rsp_valid), 32'h1);
        check("w0_store_err", 32'(z_rsp_err), 32'h0);
        check("w0_store_rdata", z_rsp_rdata, 32'h0);
        check("w0_store_busy", 32'(z_req_ready), 32'h0);
        z_req_we = 1'b0; z_req_wdata = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("w0_b2b_req_ready", 32'(z_req_ready), 32'((k % 2) == 0));
            check("w0_b2b_rsp_valid", 32'(z_rsp_valid), 32'((k % 2) == 1));
            if (k % 2 == 1) check("w0_load_rdata", z_rsp_rdata, 32'hCAFEF00D);
        end
        z_req_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
